br_write_scheduler: RTL and testbench

- Schedules the single write port of the 32x32 register bank (we, DE, Dato) between two writeback requesters: ALU (port A) and memory load (port B).
- Keeps a 32-bit busy scoreboard of destination registers reserved at issue, and tells decode to stall when a source operand is still pending.
- Sits between the decode/issue stage, the two writeback paths and the register bank.

---
 rtl/br_pkg.sv | 14 +
 rtl/br_scoreboard.sv | 66 ++++++
 rtl/br_write_scheduler.sv | 104 ++++++++++
 tb/tb_br_write_scheduler.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/br_pkg.sv
// Shared constants and the round-robin port encoding for the register-bank
// write scheduler.
package br_pkg;

  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int DW   = 32;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

endpackage

// File: rtl/br_scoreboard.sv
// Busy-register scoreboard: tracks destinations reserved at issue, counts them,
// flags writes to idle registers and raises the decode source-hazard stall.
module br_scoreboard #(
  parameter int NREG    = br_pkg::NREG,
  parameter int AW      = br_pkg::AW,
  parameter int DROP_R0 = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] DE,
  input  logic          rsv_valid,
  input  logic [AW-1:0] rsv_addr,
  input  logic [AW-1:0] DL1,
  input  logic [AW-1:0] DL2,
  input  logic          use1,
  input  logic          use2,
  output logic          stall,
  output logic [AW:0]   pending,
  output logic          err
);

  logic [NREG-1:0] busy_q, busy_d, busy_eff;
  logic [AW:0]     pending_q, pending_d;
  logic            err_q, err_d;
  logic            set_en, inc, dec;

  always_comb begin
    set_en = rsv_valid & ~((DROP_R0 != 0) && (rsv_addr == '0));
    inc    = set_en & ~busy_q[rsv_addr];
    // A clear that collides with a set on the same address is cancelled by the set.
    dec    = we & busy_q[DE] & ~(set_en && (rsv_addr == DE));

    busy_d = busy_q;
    if (we) busy_d[DE] = 1'b0;
    if (set_en) busy_d[rsv_addr] = 1'b1;

    pending_d = pending_q + {{AW{1'b0}}, inc} - {{AW{1'b0}}, dec};
    err_d     = err_q | (we & ~busy_q[DE]);
  end

  // The bank writes through combinationally, so the register being written
  // this cycle already reads its new value and must not stall decode.
  always_comb begin
    busy_eff = busy_q;
    if (we) busy_eff[DE] = 1'b0;
    if (DROP_R0 != 0) busy_eff[0] = 1'b0;
    stall = (use1 & busy_eff[DL1]) | (use2 & busy_eff[DL2]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q    <= '0;
      pending_q <= '0;
      err_q     <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      pending_q <= pending_d;
      err_q     <= err_d;
    end
  end

  assign pending = pending_q;
  assign err     = err_q;

endmodule

// File: rtl/br_write_scheduler.sv
// Arbitrates the single register-bank write port between ALU (A) and load (B)
// writeback, registers the write, and hosts the busy scoreboard.
module br_write_scheduler #(
  parameter int NREG    = br_pkg::NREG,
  parameter int AW      = br_pkg::AW,
  parameter int DW      = br_pkg::DW,
  parameter int DROP_R0 = 1,
  parameter int PRIO_B  = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_valid,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_data,
  output logic          a_ready,
  input  logic          b_valid,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_data,
  output logic          b_ready,
  input  logic          rsv_valid,
  input  logic [AW-1:0] rsv_addr,
  input  logic [AW-1:0] DL1,
  input  logic [AW-1:0] DL2,
  input  logic          use1,
  input  logic          use2,
  output logic          stall,
  output logic          we,
  output logic [AW-1:0] DE,
  output logic [DW-1:0] Dato,
  output logic [AW:0]   pending,
  output logic          err
);

  import br_pkg::*;

  port_e         rr_q, rr_d;
  logic          we_q, we_d;
  logic [AW-1:0] de_q, de_d;
  logic [DW-1:0] dato_q, dato_d;
  logic          both, win_b, grant_a, grant_b;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;
  logic          drop;

  // rr_q names the port that wins the next contended cycle.
  always_comb begin
    both    = a_valid & b_valid;
    win_b   = (PRIO_B != 0) ? 1'b1 : (rr_q == PORT_B);
    grant_a = a_valid & (~b_valid | ~win_b);
    grant_b = b_valid & (~a_valid | win_b);

    rr_d = rr_q;
    if (both) rr_d = grant_b ? PORT_A : PORT_B;

    sel_addr = grant_b ? b_addr : a_addr;
    sel_data = grant_b ? b_data : a_data;
    drop     = (DROP_R0 != 0) && (sel_addr == '0);

    we_d   = (grant_a | grant_b) & ~drop;
    de_d   = we_d ? sel_addr : de_q;
    dato_d = we_d ? sel_data : dato_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q   <= PORT_A;
      we_q   <= 1'b0;
      de_q   <= '0;
      dato_q <= '0;
    end else begin
      rr_q   <= rr_d;
      we_q   <= we_d;
      de_q   <= de_d;
      dato_q <= dato_d;
    end
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;
  assign we      = we_q;
  assign DE      = de_q;
  assign Dato    = dato_q;

  br_scoreboard #(
    .NREG    (NREG),
    .AW      (AW),
    .DROP_R0 (DROP_R0)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .we        (we_q),
    .DE        (de_q),
    .rsv_valid (rsv_valid),
    .rsv_addr  (rsv_addr),
    .DL1       (DL1),
    .DL2       (DL2),
    .use1      (use1),
    .use2      (use2),
    .stall     (stall),
    .pending   (pending),
    .err       (err)
  );

endmodule

// File: tb/tb_br_write_scheduler.sv
// Scoreboard bench for br_write_scheduler: accepted writes are queued as
// expected bank writes and matched when we rises; busy state is modelled as a bitmap.
module tb_br_write_scheduler;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid, rsv_valid, use1, use2;
  logic [4:0]  a_addr, b_addr, rsv_addr, DL1, DL2;
  logic [31:0] a_data, b_data;
  logic        a_ready, b_ready, stall, we, err;
  logic [4:0]  DE;
  logic [31:0] Dato;
  logic [5:0]  pending;

  int          vectors = 0;
  int          miscompares = 0;
  wr_t         expQ[$];
  logic [31:0] mbusy = '0;
  logic        merr = 1'b0;
  logic        mrr = 1'b0;
  logic        weNow = 1'b0;
  logic [4:0]  deNow = '0;

  br_write_scheduler #(
    .NREG(32), .AW(5), .DW(32), .DROP_R0(1), .PRIO_B(0)
  ) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
    .DL1(DL1), .DL2(DL2), .use1(use1), .use2(use2),
    .stall(stall), .we(we), .DE(DE), .Dato(Dato),
    .pending(pending), .err(err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check combinational outputs, queue accepted writes,
  // advance the busy model at the edge, then check registered outputs.
  task automatic applyStimulus();
    logic        ea, eb, es;
    logic [31:0] eff;
    wr_t         w;
    #1;
    ea = a_valid & (~b_valid | ~mrr);
    eb = b_valid & (~a_valid | mrr);
    checkOutput("a_ready", 64'(a_ready), 64'(ea));
    checkOutput("b_ready", 64'(b_ready), 64'(eb));
    eff = mbusy;
    if (weNow) eff[deNow] = 1'b0;
    eff[0] = 1'b0;
    es = (use1 & eff[DL1]) | (use2 & eff[DL2]);
    checkOutput("stall", 64'(stall), 64'(es));
    if (ea && a_addr != 5'd0) expQ.push_back({a_addr, a_data});
    if (eb && b_addr != 5'd0) expQ.push_back({b_addr, b_data});
    if (a_valid && b_valid) mrr = eb ? 1'b0 : 1'b1;
    @(posedge clk);
    if (rst) begin
      mbusy = '0;
      merr  = 1'b0;
      mrr   = 1'b0;
      expQ.delete();
    end else begin
      if (weNow) begin
        if (!mbusy[deNow]) merr = 1'b1;
        mbusy[deNow] = 1'b0;
      end
      if (rsv_valid && rsv_addr != 5'd0) mbusy[rsv_addr] = 1'b1;
    end
    #1;
    checkOutput("we", 64'(we), 64'(expQ.size() != 0));
    if (expQ.size() != 0) begin
      w = expQ.pop_front();
      checkOutput("DE", 64'(DE), 64'(w.addr));
      checkOutput("Dato", 64'(Dato), 64'(w.data));
      weNow = 1'b1;
      deNow = w.addr;
    end else begin
      weNow = 1'b0;
    end
    checkOutput("pending", 64'(pending), 64'($countones(mbusy)));
    checkOutput("err", 64'(err), 64'(merr));
  endtask

  task automatic reserve(input logic [4:0] r);
    rsv_valid = 1'b1;
    rsv_addr  = r;
    applyStimulus();
    rsv_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    a_valid = 0; b_valid = 0; rsv_valid = 0; use1 = 0; use2 = 0;
    a_addr = 0; b_addr = 0; rsv_addr = 0; DL1 = 0; DL2 = 0;
    a_data = 0; b_data = 0;
    applyStimulus();
    applyStimulus();
    rst = 1'b0;
    checkOutput("DE_reset", 64'(DE), 64'd0);
    checkOutput("Dato_reset", 64'(Dato), 64'd0);

    // Basic ALU write to a reserved register.
    reserve(5'd5);
    a_valid = 1; a_addr = 5'd5; a_data = 32'hDEADBEEF;
    applyStimulus();
    a_valid = 0;
    applyStimulus();
    applyStimulus();

    // Contention: grants alternate A, B, A, B.
    reserve(5'd1); reserve(5'd2); reserve(5'd10); reserve(5'd11);
    a_valid = 1; a_addr = 5'd1; a_data = 32'hA1A1_0001;
    b_valid = 1; b_addr = 5'd2; b_data = 32'hB2B2_0002;
    for (int i = 0; i < 4; i++) begin
      applyStimulus();
      if (i == 0) begin a_addr = 5'd10; a_data = 32'hA1A1_0010; end
      if (i == 1) begin b_addr = 5'd11; b_data = 32'hB2B2_0011; end
    end
    a_valid = 0; b_valid = 0;
    applyStimulus();
    applyStimulus();

    // Source hazard and write-through bypass.
    reserve(5'd7);
    DL1 = 5'd7; use1 = 1;
    applyStimulus();
    a_valid = 1; a_addr = 5'd7; a_data = 32'h0000_0777;
    applyStimulus();
    a_valid = 0;
    applyStimulus();
    applyStimulus();
    use1 = 0;
    reserve(5'd7);
    applyStimulus();
    DL2 = 5'd7; use2 = 1;
    applyStimulus();
    use2 = 0;

    // Reserve and write of the same register in the same cycle: set wins.
    reserve(5'd9);
    a_valid = 1; a_addr = 5'd9; a_data = 32'h9999_9999;
    applyStimulus();
    a_valid = 0;
    reserve(5'd9);
    applyStimulus();

    // Register 0 is dropped; a write to an idle register is an error.
    b_valid = 1; b_addr = 5'd0; b_data = 32'h1234_5678;
    applyStimulus();
    b_valid = 0;
    applyStimulus();
    reserve(5'd0);
    DL1 = 5'd0; use1 = 1;
    applyStimulus();
    use1 = 0;
    a_valid = 1; a_addr = 5'd3; a_data = 32'h3333_0003;
    applyStimulus();
    a_valid = 0;
    applyStimulus();
    applyStimulus();
    applyStimulus();

    // Reset mid-operation discards busy bits and the in-flight write.
    reserve(5'd12); reserve(5'd13); reserve(5'd14); reserve(5'd15);
    a_valid = 1; a_addr = 5'd12; a_data = 32'hC0C0_0012;
    rst = 1;
    applyStimulus();
    rst = 0; a_valid = 0;
    DL1 = 5'd12; use1 = 1;
    applyStimulus();
    checkOutput("pending_after_rst", 64'(pending), 64'd0);
    use1 = 0;
    applyStimulus();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
